id_queue_stage: RTL and testbench
=================================

Name: id_queue_stage

Overview:
Parametrised successor to the combinational decode stage.
- Buffers fetched instructions in a DEPTH-entry FIFO.
- Decodes the head entry across all of RV32I: LUI, AUIPC, JAL, JALR, branches, loads, stores, ALU-imm including shifts, and ALU reg-reg.
- Drives register-file read addresses and registers the result into a valid/ready output stage feeding EX.
- Sits between IF and EX, and supports flush and stall.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- XLEN, 32, data/PC/immediate width; minimum 32; immediates sign-extended to XLEN.

Ports:
- clk_in  in  1  clock, rising edge.
- rst_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global enable; 0 freezes all state.
- flush_in  in  1  discard FIFO contents and output stage.
- if_valid_in  in  1  IF presents an instruction.
- if_ready_out  out  1  FIFO can accept.
- if_pc_in  in  XLEN  instruction PC.
- if_instr_in  in  32  instruction word.
- reg1_read_out  out  1  rs1 read enable.
- reg2_read_out  out  1  rs2 read enable.
- reg1_addr_out  out  5  rs1 address.
- reg2_addr_out  out  5  rs2 address.
- reg1_data_in  in  XLEN  regfile rs1 data, same-cycle.
- reg2_data_in  in  XLEN  regfile rs2 data, same-cycle.
- ex_valid_out  out  1  output stage holds a decoded instruction.
- ex_ready_in  in  1  EX accepts.
- ex_pc_out  out  XLEN  PC.
- ex_cmd_out  out  6  command code.
- ex_reg1_out  out  XLEN  rs1 value, 0 if rs1 not read.
- ex_reg2_out  out  XLEN  rs2 value, 0 if rs2 not read.
- ex_imm_out  out  XLEN  immediate.
- ex_rd_out  out  5  destination register.
- ex_rd_we_out  out  1  destination write enable.

Behaviour:
- Reset (rst_in=0, async): FIFO pointers and count 0; ex_valid_out 0; all ex_* data outputs 0.
- Combinational outputs during reset: if_ready_out 0; reg*_read_out 0; reg*_addr_out 0.
- Push: if_valid_in && if_ready_out && rdy_in && !flush_in.
- if_ready_out = !full && rst_in.
- No same-cycle push-through when full: a pop in the same cycle does not open a slot.
- Decode is combinational on the FIFO head. reg*_addr_out/reg*_read_out are 0 when FIFO is empty.
- Output load condition: head valid && (!ex_valid_out || ex_ready_in) && rdy_in && !flush_in.
  - On load: capture decode result plus reg*_data_in; pop head; ex_valid_out=1.
- Output clear: ex_ready_in && ex_valid_out with nothing to load sets ex_valid_out=0.
- Holding: while ex_valid_out && !ex_ready_in, all ex_* outputs hold stable.
- Latency: instruction accepted at edge E0 is visible on ex_* after edge E1 (2 cycles), given EX ready and an empty FIFO.
- Throughput: 1 instruction/cycle.
- Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.
- FIFO full: count==DEPTH. FIFO empty: count==0.
- flush_in=1 at an edge: FIFO emptied; ex_valid_out=0; that cycle's push discarded. Flush has priority over push/load.
- rdy_in=0: no state changes; ready/valid still driven.
- Decode rules:
  - rd==x0: ex_rd_we_out forced 0.
  - JALR reads rs1.
  - SLLI/SRLI/SRAI: imm = zero-extended shamt[4:0]; funct7 selects SRL vs SRA.
  - ADD/SUB and SRL/SRA selected by funct7 bit 30.
  - Immediate formats: I, S, B, U, J, each sign-extended to XLEN.
- Unknown opcode/funct3: cmd=CMD_NOP (0); rd_we 0; reads 0; still passes through the pipeline.

Optional Feature:
- Macro: ID_ILLEGAL_DETECT_EN.
- With it: extra output ex_illegal_out (1 bit), registered with the other ex_* outputs.
  - Asserted for an unknown opcode, undefined funct3/funct7, or instruction[1:0]!=2'b11.
  - Reset value 0.
- Without it: the port is absent and unknown encodings silently become CMD_NOP.

Decomposition:
- Shared package/define file holds:
  - Opcode constants OP_*, FUN3_*, FUN7_*.
  - 6-bit command codes CMD_* (CMD_NOP=0).
  - The decoded-bundle field widths.
- One sub-module: id_decode_comb, a purely combinational instruction-to-{cmd, imm, rs1/rs2 enables+addrs, rd, rd_we} decoder.
- The top level holds the FIFO and the output register.

Test Plan:
- ADDI: push 0x00500093 (addi x1,x0,5), ex_ready_in=1 -> 2 cycles later ex_cmd_out=CMD_ADDI, ex_imm_out=5, ex_rd_out=1, ex_rd_we_out=1, reg1_addr_out was 0.
- Backpressure: ex_ready_in=0, push DEPTH+1 instructions -> if_ready_out drops after 4+1 accepted (DEPTH=4, plus output reg); ex_* stable; release yields in-order output, no loss/duplication.
- Flush: flush_in pulse while FIFO holds 3 and output valid -> next cycle ex_valid_out=0, if_ready_out=1; the push in the flush cycle does not appear.
- Immediates: BEQ 0xFE000EE3 -> ex_imm_out=0xFFFFFFFC; SW 0xFE112E23 -> imm=0xFFFFFFFC; JAL 0x0000006F -> imm=0; SRAI 0x4030D093 -> CMD_SRAI, imm=3.
- x0 destination: 0x00100013 (addi x0,x0,1) -> ex_rd_we_out=0.
- Async reset: assert rst_in=0 mid-stream, between edges -> ex_valid_out=0 and if_ready_out=0 immediately; after release, FIFO is empty.

Source files
------------

// File: rtl/id_queue_stage_pkg.sv
// Shared constants for the instruction-decode queue stage: RV32I opcode/funct fields,
// command codes and the decoded-bundle layout.
package id_queue_stage_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CMD_W      = 6;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] FUN3_JALR = 3'b000;
    localparam logic [2:0] FUN3_BEQ  = 3'b000;
    localparam logic [2:0] FUN3_BNE  = 3'b001;
    localparam logic [2:0] FUN3_BLT  = 3'b100;
    localparam logic [2:0] FUN3_BGE  = 3'b101;
    localparam logic [2:0] FUN3_BLTU = 3'b110;
    localparam logic [2:0] FUN3_BGEU = 3'b111;
    localparam logic [2:0] FUN3_B    = 3'b000;
    localparam logic [2:0] FUN3_H    = 3'b001;
    localparam logic [2:0] FUN3_W    = 3'b010;
    localparam logic [2:0] FUN3_BU   = 3'b100;
    localparam logic [2:0] FUN3_HU   = 3'b101;
    localparam logic [2:0] FUN3_ADD  = 3'b000;
    localparam logic [2:0] FUN3_SLL  = 3'b001;
    localparam logic [2:0] FUN3_SLT  = 3'b010;
    localparam logic [2:0] FUN3_SLTU = 3'b011;
    localparam logic [2:0] FUN3_XOR  = 3'b100;
    localparam logic [2:0] FUN3_SR   = 3'b101;
    localparam logic [2:0] FUN3_OR   = 3'b110;
    localparam logic [2:0] FUN3_AND  = 3'b111;

    localparam logic [6:0] FUN7_BASE = 7'b0000000;
    localparam logic [6:0] FUN7_ALT  = 7'b0100000;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP = 6'd0,
        CMD_LUI, CMD_AUIPC, CMD_JAL, CMD_JALR,
        CMD_BEQ, CMD_BNE, CMD_BLT, CMD_BGE, CMD_BLTU, CMD_BGEU,
        CMD_LB, CMD_LH, CMD_LW, CMD_LBU, CMD_LHU,
        CMD_SB, CMD_SH, CMD_SW,
        CMD_ADDI, CMD_SLTI, CMD_SLTIU, CMD_XORI, CMD_ORI, CMD_ANDI,
        CMD_SLLI, CMD_SRLI, CMD_SRAI,
        CMD_ADD, CMD_SUB, CMD_SLL, CMD_SLT, CMD_SLTU, CMD_XOR,
        CMD_SRL, CMD_SRA, CMD_OR, CMD_AND
    } cmd_e;

    typedef struct packed {
        cmd_e                  cmd;
        logic                  rs1_re;
        logic                  rs2_re;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  rd_we;
        logic                  illegal;
    } dec_t;

endpackage

// File: rtl/id_queue_stage_decode.sv
// Purely combinational RV32I decoder: instruction word to command, immediate,
// register-read enables/addresses and destination.
module id_decode_comb
    import id_queue_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [INSTR_W-1:0] instr_i,
    output dec_t               dec_o,
    output logic [XLEN-1:0]    imm_o
);

    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];

    assign imm_i  = XLEN'($signed(instr_i[31:20]));
    assign imm_s  = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
    assign imm_b  = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}));
    assign imm_u  = XLEN'($signed({instr_i[31:12], 12'b0}));
    assign imm_j  = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}));
    assign imm_sh = XLEN'(instr_i[24:20]);

    cmd_e            cmd;
    logic            rs1_re, rs2_re, has_rd, bad_f7;
    logic [XLEN-1:0] imm;

    // Each opcode picks its command from funct3; NOP means the encoding was not recognised.
    always_comb begin
        cmd    = CMD_NOP;
        rs1_re = 1'b0;
        rs2_re = 1'b0;
        has_rd = 1'b0;
        bad_f7 = 1'b0;
        imm    = '0;
        case (opcode)
            OP_LUI:   begin cmd = CMD_LUI;   imm = imm_u; has_rd = 1'b1; end
            OP_AUIPC: begin cmd = CMD_AUIPC; imm = imm_u; has_rd = 1'b1; end
            OP_JAL:   begin cmd = CMD_JAL;   imm = imm_j; has_rd = 1'b1; end
            OP_JALR: begin
                if (f3 == FUN3_JALR) begin
                    cmd = CMD_JALR; imm = imm_i; rs1_re = 1'b1; has_rd = 1'b1;
                end
            end
            OP_BRANCH: begin
                case (f3)
                    FUN3_BEQ:  cmd = CMD_BEQ;
                    FUN3_BNE:  cmd = CMD_BNE;
                    FUN3_BLT:  cmd = CMD_BLT;
                    FUN3_BGE:  cmd = CMD_BGE;
                    FUN3_BLTU: cmd = CMD_BLTU;
                    FUN3_BGEU: cmd = CMD_BGEU;
                    default:   cmd = CMD_NOP;
                endcase
                if (cmd != CMD_NOP) begin imm = imm_b; rs1_re = 1'b1; rs2_re = 1'b1; end
            end
            OP_LOAD: begin
                case (f3)
                    FUN3_B:  cmd = CMD_LB;
                    FUN3_H:  cmd = CMD_LH;
                    FUN3_W:  cmd = CMD_LW;
                    FUN3_BU: cmd = CMD_LBU;
                    FUN3_HU: cmd = CMD_LHU;
                    default: cmd = CMD_NOP;
                endcase
                if (cmd != CMD_NOP) begin imm = imm_i; rs1_re = 1'b1; has_rd = 1'b1; end
            end
            OP_STORE: begin
                case (f3)
                    FUN3_B:  cmd = CMD_SB;
                    FUN3_H:  cmd = CMD_SH;
                    FUN3_W:  cmd = CMD_SW;
                    default: cmd = CMD_NOP;
                endcase
                if (cmd != CMD_NOP) begin imm = imm_s; rs1_re = 1'b1; rs2_re = 1'b1; end
            end
            OP_IMM: begin
                rs1_re = 1'b1;
                has_rd = 1'b1;
                imm    = imm_i;
                case (f3)
                    FUN3_ADD:  cmd = CMD_ADDI;
                    FUN3_SLT:  cmd = CMD_SLTI;
                    FUN3_SLTU: cmd = CMD_SLTIU;
                    FUN3_XOR:  cmd = CMD_XORI;
                    FUN3_OR:   cmd = CMD_ORI;
                    FUN3_AND:  cmd = CMD_ANDI;
                    FUN3_SLL: begin
                        cmd = CMD_SLLI; imm = imm_sh; bad_f7 = (f7 != FUN7_BASE);
                    end
                    default: begin
                        cmd    = instr_i[30] ? CMD_SRAI : CMD_SRLI;
                        imm    = imm_sh;
                        bad_f7 = (f7 != FUN7_BASE) && (f7 != FUN7_ALT);
                    end
                endcase
            end
            OP_REG: begin
                rs1_re = 1'b1;
                rs2_re = 1'b1;
                has_rd = 1'b1;
                bad_f7 = (f7 != FUN7_BASE);
                case (f3)
                    FUN3_ADD: begin
                        cmd    = instr_i[30] ? CMD_SUB : CMD_ADD;
                        bad_f7 = (f7 != FUN7_BASE) && (f7 != FUN7_ALT);
                    end
                    FUN3_SLL:  cmd = CMD_SLL;
                    FUN3_SLT:  cmd = CMD_SLT;
                    FUN3_SLTU: cmd = CMD_SLTU;
                    FUN3_XOR:  cmd = CMD_XOR;
                    FUN3_OR:   cmd = CMD_OR;
                    FUN3_AND:  cmd = CMD_AND;
                    default: begin
                        cmd    = instr_i[30] ? CMD_SRA : CMD_SRL;
                        bad_f7 = (f7 != FUN7_BASE) && (f7 != FUN7_ALT);
                    end
                endcase
            end
            default: cmd = CMD_NOP;
        endcase
    end

    always_comb begin
        dec_o         = '0;
        dec_o.cmd     = cmd;
        dec_o.rs1_re  = rs1_re;
        dec_o.rs2_re  = rs2_re;
        dec_o.rs1     = rs1_re ? instr_i[19:15] : '0;
        dec_o.rs2     = rs2_re ? instr_i[24:20] : '0;
        dec_o.rd      = has_rd ? instr_i[11:7] : '0;
        dec_o.rd_we   = has_rd && (instr_i[11:7] != '0);
        dec_o.illegal = (cmd == CMD_NOP) || bad_f7;
        imm_o         = imm;
    end

endmodule

// File: rtl/id_queue_stage.sv
// Decode stage: DEPTH-entry instruction FIFO feeding a registered valid/ready EX stage.
// Define ID_ILLEGAL_DETECT_EN to add the registered ex_illegal_out flag.
module id_queue_stage
    import id_queue_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    input  logic                  if_valid_in,
    output logic                  if_ready_out,
    input  logic [XLEN-1:0]       if_pc_in,
    input  logic [INSTR_W-1:0]    if_instr_in,
    output logic                  reg1_read_out,
    output logic                  reg2_read_out,
    output logic [REG_ADDR_W-1:0] reg1_addr_out,
    output logic [REG_ADDR_W-1:0] reg2_addr_out,
    input  logic [XLEN-1:0]       reg1_data_in,
    input  logic [XLEN-1:0]       reg2_data_in,
    output logic                  ex_valid_out,
    input  logic                  ex_ready_in,
    output logic [XLEN-1:0]       ex_pc_out,
    output logic [CMD_W-1:0]      ex_cmd_out,
    output logic [XLEN-1:0]       ex_reg1_out,
    output logic [XLEN-1:0]       ex_reg2_out,
    output logic [XLEN-1:0]       ex_imm_out,
    output logic [REG_ADDR_W-1:0] ex_rd_out,
`ifdef ID_ILLEGAL_DETECT_EN
    output logic                  ex_illegal_out,
`endif
    output logic                  ex_rd_we_out
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [XLEN-1:0]    pc_mem_q    [DEPTH];
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic                  ex_valid_q, ex_valid_d, ex_we_q, ex_we_d, ex_ill_q, ex_ill_d;
    logic [XLEN-1:0]       ex_pc_q, ex_pc_d, ex_reg1_q, ex_reg1_d;
    logic [XLEN-1:0]       ex_reg2_q, ex_reg2_d, ex_imm_q, ex_imm_d;
    logic [CMD_W-1:0]      ex_cmd_q, ex_cmd_d;
    logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;

    logic               full, head_valid, push, load;
    logic [INSTR_W-1:0] head_instr;
    logic [XLEN-1:0]    dec_imm;
    dec_t               dec;

    assign full         = (cnt_q == CNT_W'(DEPTH));
    assign head_valid   = (cnt_q != '0);
    assign if_ready_out = !full && rst_in;
    assign push = if_valid_in && if_ready_out && rdy_in && !flush_in;
    assign load = head_valid && (!ex_valid_q || ex_ready_in) && rdy_in && !flush_in;

    // An empty FIFO presents an all-zero word, which decodes to NOP with no reads.
    assign head_instr = head_valid ? instr_mem_q[rd_q] : '0;

    id_decode_comb #(.XLEN(XLEN)) u_decode (
        .instr_i (head_instr),
        .dec_o   (dec),
        .imm_o   (dec_imm)
    );

    assign reg1_read_out = dec.rs1_re;
    assign reg2_read_out = dec.rs2_re;
    assign reg1_addr_out = dec.rs1;
    assign reg2_addr_out = dec.rs2;

    always_ff @(posedge clk_in) begin
        if (push) begin
            pc_mem_q[wr_q]    <= if_pc_in;
            instr_mem_q[wr_q] <= if_instr_in;
        end
    end

    // Next state: flush wins, rdy_in=0 freezes everything.
    always_comb begin
        wr_d       = wr_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        ex_valid_d = ex_valid_q;
        ex_pc_d    = ex_pc_q;
        ex_cmd_d   = ex_cmd_q;
        ex_reg1_d  = ex_reg1_q;
        ex_reg2_d  = ex_reg2_q;
        ex_imm_d   = ex_imm_q;
        ex_rd_d    = ex_rd_q;
        ex_we_d    = ex_we_q;
        ex_ill_d   = ex_ill_q;
        if (flush_in) begin
            wr_d       = '0;
            rd_d       = '0;
            cnt_d      = '0;
            ex_valid_d = 1'b0;
        end else if (rdy_in) begin
            if (push) wr_d = wr_q + PTR_W'(1);
            if (load) rd_d = rd_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(load);
            if (load) begin
                ex_valid_d = 1'b1;
                ex_pc_d    = pc_mem_q[rd_q];
                ex_cmd_d   = CMD_W'(dec.cmd);
                ex_reg1_d  = dec.rs1_re ? reg1_data_in : '0;
                ex_reg2_d  = dec.rs2_re ? reg2_data_in : '0;
                ex_imm_d   = dec_imm;
                ex_rd_d    = dec.rd;
                ex_we_d    = dec.rd_we;
                ex_ill_d   = dec.illegal;
            end else if (ex_ready_in && ex_valid_q) begin
                ex_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            ex_valid_q <= 1'b0;
            ex_pc_q    <= '0;
            ex_cmd_q   <= '0;
            ex_reg1_q  <= '0;
            ex_reg2_q  <= '0;
            ex_imm_q   <= '0;
            ex_rd_q    <= '0;
            ex_we_q    <= 1'b0;
            ex_ill_q   <= 1'b0;
        end else begin
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            ex_valid_q <= ex_valid_d;
            ex_pc_q    <= ex_pc_d;
            ex_cmd_q   <= ex_cmd_d;
            ex_reg1_q  <= ex_reg1_d;
            ex_reg2_q  <= ex_reg2_d;
            ex_imm_q   <= ex_imm_d;
            ex_rd_q    <= ex_rd_d;
            ex_we_q    <= ex_we_d;
            ex_ill_q   <= ex_ill_d;
        end
    end

    assign ex_valid_out = ex_valid_q;
    assign ex_pc_out    = ex_pc_q;
    assign ex_cmd_out   = ex_cmd_q;
    assign ex_reg1_out  = ex_reg1_q;
    assign ex_reg2_out  = ex_reg2_q;
    assign ex_imm_out   = ex_imm_q;
    assign ex_rd_out    = ex_rd_q;
    assign ex_rd_we_out = ex_we_q;

`ifdef ID_ILLEGAL_DETECT_EN
    assign ex_illegal_out = ex_ill_q;
`else
    logic ill_unused;
    assign ill_unused = ex_ill_q;
`endif

endmodule

// File: tb/tb_id_queue_stage.sv
// Scoreboard bench for id_queue_stage: directed RV32I vectors with hand-computed results.
module tb_id_queue_stage;
    import id_queue_stage_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [5:0]  cmd;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    logic        clk, rst_in, rdy_in, flush_in, if_valid_in, if_ready_out;
    logic [31:0] if_pc_in, if_instr_in;
    logic        reg1_read_out, reg2_read_out;
    logic [4:0]  reg1_addr_out, reg2_addr_out;
    logic [31:0] reg1_data_in, reg2_data_in;
    logic        ex_valid_out, ex_ready_in, ex_rd_we_out, got_ill;
    logic [31:0] ex_pc_out, ex_reg1_out, ex_reg2_out, ex_imm_out;
    logic [5:0]  ex_cmd_out;
    logic [4:0]  ex_rd_out;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    exp_t vt[11];
    logic [31:0] vi[11];
`ifdef ID_ILLEGAL_DETECT_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
    assign got_ill = 1'b0;
`endif

    id_queue_stage #(.DEPTH(4), .XLEN(32)) dut (
        .clk_in        (clk),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush_in      (flush_in),
        .if_valid_in   (if_valid_in),
        .if_ready_out  (if_ready_out),
        .if_pc_in      (if_pc_in),
        .if_instr_in   (if_instr_in),
        .reg1_read_out (reg1_read_out),
        .reg2_read_out (reg2_read_out),
        .reg1_addr_out (reg1_addr_out),
        .reg2_addr_out (reg2_addr_out),
        .reg1_data_in  (reg1_data_in),
        .reg2_data_in  (reg2_data_in),
        .ex_valid_out  (ex_valid_out),
        .ex_ready_in   (ex_ready_in),
        .ex_pc_out     (ex_pc_out),
        .ex_cmd_out    (ex_cmd_out),
        .ex_reg1_out   (ex_reg1_out),
        .ex_reg2_out   (ex_reg2_out),
        .ex_imm_out    (ex_imm_out),
        .ex_rd_out     (ex_rd_out),
`ifdef ID_ILLEGAL_DETECT_EN
        .ex_illegal_out(got_ill),
`endif
        .ex_rd_we_out  (ex_rd_we_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file model: recognisable value when read, garbage otherwise.
    assign reg1_data_in = reg1_read_out ? (32'h1111_0000 | {27'b0, reg1_addr_out}) : 32'hDEAD_BEEF;
    assign reg2_data_in = reg2_read_out ? (32'h2222_0000 | {27'b0, reg2_addr_out}) : 32'hCAFE_F00D;

    function automatic exp_t mk(logic [5:0] c, logic [31:0] r1, logic [31:0] r2,
                                logic [31:0] imm, logic [4:0] rd, logic we, logic ill);
        exp_t e;
        e.pc = 32'h0; e.cmd = c; e.r1 = r1; e.r2 = r2; e.imm = imm;
        e.rd = rd; e.we = we; e.ill = ill;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    // Drive one instruction until accepted (bounded), then record its expected output.
    task automatic push_v(input int idx, input logic [31:0] pc);
        exp_t e;
        int   n;
        n = 0;
        e = vt[idx];
        e.pc = pc;
        if_valid_in = 1'b1;
        if_instr_in = vi[idx];
        if_pc_in    = pc;
        @(negedge clk);
        while (!if_ready_out && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!if_ready_out) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: got if_ready_out 0 for pc %h, want 1", pc);
        end
        @(posedge clk);
        #1;
        if (n < 50) sb.push_back(e);
        if_valid_in = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    // Monitor: compare whatever the DUT presents against the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_in && rdy_in && !flush_in && ex_valid_out) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_output: got pc %h cmd %0d, want no output", ex_pc_out, ex_cmd_out);
            end else begin
                e = sb[0];
                if ({ex_pc_out, ex_cmd_out, ex_reg1_out, ex_reg2_out, ex_imm_out, ex_rd_out, ex_rd_we_out, got_ill} !==
                    {e.pc, e.cmd, e.r1, e.r2, e.imm, e.rd, e.we, ILL_EN ? e.ill : 1'b0}) begin
                    n_bad++;
                    $display("FAIL ex_bundle pc %h: got cmd %0d r1 %h r2 %h imm %h rd %0d we %b ill %b, want pc %h cmd %0d r1 %h r2 %h imm %h rd %0d we %b ill %b",
                             e.pc, ex_cmd_out, ex_reg1_out, ex_reg2_out, ex_imm_out, ex_rd_out, ex_rd_we_out, got_ill,
                             ex_pc_out, e.cmd, e.r1, e.r2, e.imm, e.rd, e.we, ILL_EN ? e.ill : 1'b0);
                end
                if (ex_ready_in) void'(sb.pop_front());
            end
        end
    end

    initial begin
        vi[0]  = 32'h0050_0093; vt[0]  = mk(CMD_ADDI, 32'h1111_0000, 32'h0, 32'h5, 5'd1, 1'b1, 1'b0);
        vi[1]  = 32'hFE00_0EE3; vt[1]  = mk(CMD_BEQ,  32'h1111_0000, 32'h2222_0000, 32'hFFFF_FFFC, 5'd0, 1'b0, 1'b0);
        vi[2]  = 32'hFE11_2E23; vt[2]  = mk(CMD_SW,   32'h1111_0002, 32'h2222_0001, 32'hFFFF_FFFC, 5'd0, 1'b0, 1'b0);
        vi[3]  = 32'h0000_006F; vt[3]  = mk(CMD_JAL,  32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        vi[4]  = 32'h4030_D093; vt[4]  = mk(CMD_SRAI, 32'h1111_0001, 32'h0, 32'h3, 5'd1, 1'b1, 1'b0);
        vi[5]  = 32'h0010_0013; vt[5]  = mk(CMD_ADDI, 32'h1111_0000, 32'h0, 32'h1, 5'd0, 1'b0, 1'b0);
        vi[6]  = 32'h1234_50B7; vt[6]  = mk(CMD_LUI,  32'h0, 32'h0, 32'h1234_5000, 5'd1, 1'b1, 1'b0);
        vi[7]  = 32'h4020_81B3; vt[7]  = mk(CMD_SUB,  32'h1111_0001, 32'h2222_0002, 32'h0, 5'd3, 1'b1, 1'b0);
        vi[8]  = 32'h0000_0000; vt[8]  = mk(CMD_NOP,  32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
        vi[9]  = 32'h0000_80E7; vt[9]  = mk(CMD_JALR, 32'h1111_0001, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0);
        vi[10] = 32'hFFC1_2283; vt[10] = mk(CMD_LW,   32'h1111_0002, 32'h0, 32'hFFFF_FFFC, 5'd5, 1'b1, 1'b0);

        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; if_valid_in = 1'b0;
        if_pc_in = 32'h0; if_instr_in = 32'h0; ex_ready_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ex_valid", 32'(ex_valid_out), 32'd0);
        chk("reset_if_ready", 32'(if_ready_out), 32'd0);
        chk("reset_reg1_read", 32'(reg1_read_out), 32'd0);
        chk("reset_ex_imm", ex_imm_out, 32'd0);
        rst_in = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_if_ready", 32'(if_ready_out), 32'd1);

        // Latency: ADDI accepted at E0 appears after E1
        push_v(0, 32'h100);
        chk("addi_reg1_read", 32'(reg1_read_out), 32'd1);
        chk("addi_reg1_addr", 32'(reg1_addr_out), 32'd0);
        chk("addi_not_yet_valid", 32'(ex_valid_out), 32'd0);
        @(posedge clk);
        #1;
        chk("addi_valid_e1", 32'(ex_valid_out), 32'd1);
        chk("addi_cmd_e1", 32'(ex_cmd_out), 32'(CMD_ADDI));
        drain("drain_latency");

        // Throughput: back-to-back vectors with EX always ready
        for (int i = 1; i < 11; i++) push_v(i, 32'h200 + 32'(4 * i));
        drain("drain_stream");

        // Backpressure: output reg + 4 FIFO entries fill, then IF stalls
        ex_ready_in = 1'b0;
        for (int i = 1; i < 6; i++) push_v(i, 32'h300 + 32'(4 * i));
        if_valid_in = 1'b1;
        if_instr_in = vi[6];
        @(negedge clk);
        chk("full_if_ready", 32'(if_ready_out), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        ex_ready_in = 1'b1;
        push_v(6, 32'h318);
        for (int i = 7; i < 11; i++) push_v(i, 32'h300 + 32'(4 * i));
        drain("drain_backpressure");

        // Flush with 3 queued and output valid; the flush-cycle push is dropped
        ex_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) push_v(i, 32'h400 + 32'(4 * i));
        flush_in = 1'b1;
        if_valid_in = 1'b1;
        if_instr_in = vi[6];
        if_pc_in = 32'h4F0;
        @(posedge clk);
        #1;
        flush_in = 1'b0;
        if_valid_in = 1'b0;
        sb.delete();
        chk("flush_ex_valid", 32'(ex_valid_out), 32'd0);
        chk("flush_if_ready", 32'(if_ready_out), 32'd1);
        chk("flush_fifo_empty_read", 32'(reg1_read_out), 32'd0);
        ex_ready_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("flush_no_ghost", 32'(ex_valid_out), 32'd0);
        push_v(7, 32'h500);
        drain("drain_after_flush");

        // rdy_in low: nothing accepted or moved
        rdy_in = 1'b0;
        if_valid_in = 1'b1;
        if_instr_in = vi[0];
        repeat (3) @(posedge clk);
        #1;
        chk("rdy_low_if_ready_driven", 32'(if_ready_out), 32'd1);
        chk("rdy_low_ex_valid", 32'(ex_valid_out), 32'd0);
        if_valid_in = 1'b0;
        rdy_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rdy_low_no_push", 32'(ex_valid_out), 32'd0);

        // Async reset between edges with work in flight
        ex_ready_in = 1'b0;
        push_v(9, 32'h600);
        push_v(10, 32'h604);
        push_v(0, 32'h608);
        #2;
        rst_in = 1'b0;
        #1;
        chk("async_rst_ex_valid", 32'(ex_valid_out), 32'd0);
        chk("async_rst_if_ready", 32'(if_ready_out), 32'd0);
        sb.delete();
        @(negedge clk);
        #2;
        rst_in = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_release_if_ready", 32'(if_ready_out), 32'd1);
        chk("rst_release_fifo_empty", 32'(reg1_read_out), 32'd0);
        chk("rst_release_ex_valid", 32'(ex_valid_out), 32'd0);
        ex_ready_in = 1'b1;
        push_v(4, 32'h700);
        drain("drain_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog");
    end

endmodule
